// File: rtl/mtsp_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mtsp_wb_arbiter
// Brief    : Two-port GPR writeback arbiter. ALU results own their writeback
//            port outright; load returns are queued in a 4-entry FIFO and fill
//            whichever port an ALU leaves idle, oldest entry first.
// Revision : 1.0 - initial release
// ============================================================================
module mtsp_wb_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int TRD_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ALU0_nEN,
    input  logic [TRD_W-1:0]  ALU0_TRD,
    input  logic [3:0]        ALU0_WMASK,
    input  logic [ADDR_W-1:0] ALU0_ADDR,
    input  logic [127:0]      ALU0_DATA,
    input  logic              ALU1_nEN,
    input  logic [TRD_W-1:0]  ALU1_TRD,
    input  logic [3:0]        ALU1_WMASK,
    input  logic [ADDR_W-1:0] ALU1_ADDR,
    input  logic [127:0]      ALU1_DATA,
    input  logic              LD_VALID,
    output logic              LD_READY,
    input  logic [TRD_W-1:0]  LD_TRD,
    input  logic [3:0]        LD_WMASK,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [127:0]      LD_DATA,
    output logic              WB0_nEN,
    output logic [TRD_W-1:0]  WB0_TRD,
    output logic [3:0]        WB0_WMASK,
    output logic [ADDR_W-1:0] WB0_ADDR,
    output logic [127:0]      WB0_DATA,
    output logic              WB1_nEN,
    output logic [TRD_W-1:0]  WB1_TRD,
    output logic [3:0]        WB1_WMASK,
    output logic [ADDR_W-1:0] WB1_ADDR,
    output logic [127:0]      WB1_DATA,
    output logic [2:0]        FIFO_LEVEL,
    output logic              STARVE,
    output logic              WB_CONFLICT
);

    // A writeback entry is packed as {trd, wmask, addr, data}.
    localparam int c_ADDR_LO = 128;
    localparam int c_ADDR_HI = c_ADDR_LO + ADDR_W - 1;
    localparam int c_MASK_LO = c_ADDR_LO + ADDR_W;
    localparam int c_MASK_HI = c_MASK_LO + 3;
    localparam int c_TRD_LO  = c_MASK_LO + 4;
    localparam int c_TRD_HI  = c_TRD_LO + TRD_W - 1;
    localparam int c_ENT_W   = c_TRD_LO + TRD_W;
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [2:0] c_FULL = 3'(FIFO_DEPTH);

    logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [2:0]         r_level;
    logic [3:0]         r_starve_cnt;
    logic               r_conflict;
    logic               r_wb0_nen;
    logic               r_wb1_nen;
    logic [c_ENT_W-1:0] r_wb0_ent;
    logic [c_ENT_W-1:0] r_wb1_ent;

    logic [c_ENT_W-1:0] w_alu0_ent;
    logic [c_ENT_W-1:0] w_alu1_ent;
    logic [c_ENT_W-1:0] w_ld_ent;
    logic [c_ENT_W-1:0] w_head;
    logic [c_ENT_W-1:0] w_next;
    logic [c_PTR_W-1:0] w_next_ptr;
    logic               w_push;
    logic [1:0]         w_pop_cnt;
    logic               w_wb0_wr;
    logic               w_wb1_wr;
    logic [c_ENT_W-1:0] w_wb0_ent;
    logic [c_ENT_W-1:0] w_wb1_ent;
    logic               w_collide;

    assign w_alu0_ent = {ALU0_TRD, ALU0_WMASK, ALU0_ADDR, ALU0_DATA};
    assign w_alu1_ent = {ALU1_TRD, ALU1_WMASK, ALU1_ADDR, ALU1_DATA};
    assign w_ld_ent   = {LD_TRD, LD_WMASK, LD_ADDR, LD_DATA};

    // Readiness looks only at the registered level so it never depends on
    // this cycle's pops; entries pushed now are not drainable until next edge.
    assign LD_READY   = (r_level != c_FULL) && !RST;
    assign w_push     = LD_VALID && LD_READY;
    assign w_next_ptr = r_rd_ptr + c_PTR_W'(1);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_next     = r_mem[w_next_ptr];

    // Port selection: ALU wins its port; idle ports take FIFO entries in order.
    always_comb begin
        w_pop_cnt = 2'd0;
        w_wb0_wr  = 1'b0;
        w_wb1_wr  = 1'b0;
        w_wb0_ent = w_alu0_ent;
        w_wb1_ent = w_alu1_ent;
        if (!ALU0_nEN) begin
            w_wb0_wr = 1'b1;
        end else if (r_level != 3'd0) begin
            w_wb0_wr  = 1'b1;
            w_wb0_ent = w_head;
            w_pop_cnt = 2'd1;
        end
        if (!ALU1_nEN) begin
            w_wb1_wr = 1'b1;
        end else if (r_level > {1'b0, w_pop_cnt}) begin
            w_wb1_wr  = 1'b1;
            w_wb1_ent = (w_pop_cnt == 2'd0) ? w_head : w_next;
            w_pop_cnt = w_pop_cnt + 2'd1;
        end
    end

    assign w_collide = w_wb0_wr && w_wb1_wr
                    && (w_wb0_ent[c_TRD_HI:c_TRD_LO]   == w_wb1_ent[c_TRD_HI:c_TRD_LO])
                    && (w_wb0_ent[c_ADDR_HI:c_ADDR_LO] == w_wb1_ent[c_ADDR_HI:c_ADDR_LO])
                    && ((w_wb0_ent[c_MASK_HI:c_MASK_LO] & w_wb1_ent[c_MASK_HI:c_MASK_LO]) != 4'd0);

    // FIFO storage: contents need no reset, the pointers define validity.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_ld_ent;
        end
    end

    // FIFO pointers, level, starvation counter and sticky conflict flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_level      <= 3'd0;
            r_starve_cnt <= 4'd0;
            r_conflict   <= 1'b0;
        end else begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_pop_cnt);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            r_level <= r_level + {2'b00, w_push} - {1'b0, w_pop_cnt};
            if ((w_pop_cnt != 2'd0) || (r_level == 3'd0)) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != 4'hF) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            if (w_collide) begin
                r_conflict <= 1'b1;
            end
        end
    end

    // Writeback output registers; fields hold when the port is not written.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wb0_nen <= 1'b1;
            r_wb1_nen <= 1'b1;
            r_wb0_ent <= '0;
            r_wb1_ent <= '0;
        end else begin
            r_wb0_nen <= !w_wb0_wr;
            r_wb1_nen <= !w_wb1_wr;
            if (w_wb0_wr) begin
                r_wb0_ent <= w_wb0_ent;
            end
            if (w_wb1_wr) begin
                r_wb1_ent <= w_wb1_ent;
            end
        end
    end

    assign WB0_nEN     = r_wb0_nen;
    assign WB0_TRD     = r_wb0_ent[c_TRD_HI:c_TRD_LO];
    assign WB0_WMASK   = r_wb0_ent[c_MASK_HI:c_MASK_LO];
    assign WB0_ADDR    = r_wb0_ent[c_ADDR_HI:c_ADDR_LO];
    assign WB0_DATA    = r_wb0_ent[127:0];
    assign WB1_nEN     = r_wb1_nen;
    assign WB1_TRD     = r_wb1_ent[c_TRD_HI:c_TRD_LO];
    assign WB1_WMASK   = r_wb1_ent[c_MASK_HI:c_MASK_LO];
    assign WB1_ADDR    = r_wb1_ent[c_ADDR_HI:c_ADDR_LO];
    assign WB1_DATA    = r_wb1_ent[127:0];
    assign FIFO_LEVEL  = r_level;
    assign STARVE      = (r_starve_cnt == 4'hF);
    assign WB_CONFLICT = r_conflict;

endmodule
`default_nettype wire

// File: doc/mtsp_wb_arbiter.md
MTSP_WB_ARBITER -- requirements
Module: mtsp_wb_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 6, GPR index width; TRD_W, default 4, thread ID width; FIFO_DEPTH, fixed 4, load-return buffer entries.
REQ-002 SHALL have port CLK  input  1  main clock, single clock domain, all state on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports ALUk_nEN  input  1  ALU writeback request for port k, active low, k=0,1.
REQ-005 SHALL have ports ALUk_TRD  input  TRD_W, ALUk_WMASK  input  4, ALUk_ADDR  input  ADDR_W, ALUk_DATA  input  128; these carry the ALU request fields, k=0,1.
REQ-006 SHALL have port LD_VALID  input  1  load-return request valid.
REQ-007 SHALL have port LD_READY  output  1  load-return accept.
REQ-008 SHALL have ports LD_TRD  input  TRD_W, LD_WMASK  input  4, LD_ADDR  input  ADDR_W, LD_DATA  input  128; these carry the load-return fields.
REQ-009 SHALL have ports WBk_nEN  output  1, WBk_TRD  output  TRD_W, WBk_WMASK  output  4, WBk_ADDR  output  ADDR_W, WBk_DATA  output  128; these form GPR writeback port k, k=0,1.
REQ-010 SHALL have port FIFO_LEVEL  output  3  load buffer occupancy, 0..4.
REQ-011 SHALL have port STARVE  output  1  request to the issue stage to insert an ALU bubble.
REQ-012 SHALL have port WB_CONFLICT  output  1  sticky flag for a same-cycle write collision.

Function
REQ-013 SHALL register every WB output; an ALUk request sampled at edge N SHALL appear on WBk after edge N, giving 1-cycle latency.
REQ-014 SHALL give ALUk absolute priority on WBk; ALU requests are never stalled or dropped.
REQ-015 SHALL accept a load at edge N when LD_VALID=1 and LD_READY=1, and push it into the FIFO.
REQ-016 SHALL drive LD_READY = (level != 4) && !RST, decoded from the registered level only and never from same-cycle pops.
REQ-017 SHALL drain the FIFO in order: head goes to WB0 if ALU0_nEN=1, else to WB1 if ALU1_nEN=1.
REQ-018 SHALL pop two entries when both ALU ports are idle and level >= 2: head to WB0, next entry to WB1.
REQ-019 SHALL NOT bypass the FIFO; a load accepted at edge N reaches WB no earlier than after edge N+1.
REQ-020 SHALL update the level as level + push - pops in one edge when a push and a pop occur simultaneously, including push with pop at level 3 and push into an empty FIFO while nothing pops.
REQ-021 SHALL wrap the read and write pointers modulo 4; level 4 is full and level 0 is empty, and a pop from empty SHALL NOT occur.
REQ-022 SHALL drive WBk_nEN=1 after any edge where port k received neither an ALU nor a FIFO write, and SHALL hold the other WBk fields at their previous values.
REQ-023 SHALL keep a 4-bit starvation counter, behaving per edge as follows:
- clear it on any pop or when level=0;
- otherwise increment it, saturating at 15.
REQ-024 SHALL drive STARVE=1 while the starvation counter equals 15; STARVE SHALL fall after the first edge with a pop.
REQ-025 SHALL set WB_CONFLICT when an edge loads both WB ports with nEN=0, equal TRD, equal ADDR and (WB0_WMASK & WB1_WMASK) != 0; both writes still issue, and the flag clears only on RST.
REQ-026 SHALL drive FIFO_LEVEL equal to the registered level.

Reset
REQ-027 SHALL, on an edge with RST=1, set WB0_nEN=WB1_nEN=1, all other WB fields 0, level 0, pointers 0, starvation counter 0, STARVE 0 and WB_CONFLICT 0.
REQ-028 SHALL discard FIFO contents on RST asserted mid-operation, with no WB writes issued at the edge where RST=1 is sampled.
REQ-029 SHALL hold LD_READY=0 while RST=1 and set it to 1 from the first cycle after release.

Verification
REQ-030 Bench SHALL cover ALU0 and ALU1 requests only (TRD 3/5, ADDR 0x10/0x11) -> WB0/WB1 show matching fields one edge later, FIFO_LEVEL=0.
REQ-031 Bench SHALL cover four loads pushed back-to-back while both ALUs are busy -> FIFO_LEVEL climbs 1..4, LD_READY=0 at level 4, and STARVE=1 after 15 no-pop edges; releasing ALU1 drains one entry to WB1, then STARVE=0.
REQ-032 Bench SHALL cover level 3 with both ALUs idle and a push in the same edge -> two pops in order (head->WB0), FIFO_LEVEL=2.
REQ-033 Bench SHALL cover ALU0 and ALU1 both writing TRD 2, ADDR 0x05, masks 0011 and 0110 -> WB_CONFLICT=1, which holds until RST.
REQ-034 Bench SHALL cover RST asserted with level 3 and ALU requests pending -> the next cycle shows WBk_nEN=1, FIFO_LEVEL=0 and LD_READY=0, then LD_READY=1 after release.
REQ-035 Bench SHALL cover a load accepted at edge N into an empty FIFO with ALUs idle -> WB0 carries it after edge N+1 and not before.
